// File: rtl/systolic_spi_host.sv
// SPI mode-0 master: turns one register request into a {cmd, addr, data} frame
// and returns the trailing DATA_W bits sampled from miso; also syncs the accelerator irq.
module systolic_spi_host #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_cmd,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  input  logic              irq_in,
  output logic              irq_sync,
  output logic              irq_rise
);

  localparam int N  = 16 + DATA_W;
  localparam int NW = $clog2(N);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [NW-1:0]     bit_idx;
  logic [N-1:0]      shreg;
  logic [DATA_W-1:0] rx;
  logic              irq_meta;
  logic              last_half;

  assign last_half = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx        <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            shreg     <= {req_cmd, req_addr, req_wdata};
            mosi      <= req_cmd[7];
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (last_half) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            rx    <= {rx[DATA_W-2:0], miso};
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // sclk itself tells which half-period just ended: falling edges shift mosi,
        // rising edges capture miso into a window that keeps only the newest DATA_W bits.
        SHIFT: begin
          if (last_half) begin
            cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_idx == NW'(N - 1)) begin
                mosi  <= 1'b0;
                state <= HOLD;
              end else begin
                mosi    <= shreg[N-2];
                shreg   <= shreg << 1;
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              sclk <= 1'b1;
              rx   <= {rx[DATA_W-2:0], miso};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (last_half) begin
            cnt       <= '0;
            cs_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx;
            state     <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (last_half) begin
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // irq_rise is registered alongside irq_sync so it lines up with irq_sync's first high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta <= 1'b0;
      irq_sync <= 1'b0;
      irq_rise <= 1'b0;
    end else begin
      irq_meta <= irq_in;
      irq_sync <= irq_meta;
      irq_rise <= irq_meta & ~irq_sync;
    end
  end

endmodule

// File: tb/tb_systolic_spi_host.sv
// Self-checking bench for systolic_spi_host: a bus monitor and SPI slave feed a
// frame-level reference model (bit strings, event cycles) for each scenario task.
module tb_systolic_spi_host;

  localparam int DATA_W = 16;
  localparam int D      = 2;
  localparam int N      = 16 + DATA_W;
  localparam int FRAME_CYC = (2 * N + 2) * D + 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        req_cmd = '0;
  logic [7:0]        req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy, sclk, mosi, cs_n, irq_sync, irq_rise;
  logic              miso = 1'b0;
  logic              irq_in = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  systolic_spi_host #(.DATA_W(DATA_W), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n), .irq_in(irq_in),
    .irq_sync(irq_sync), .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus monitor: records frame events with the cycle they were first seen.
  int          cs_fall_q[$], cs_rise_q[$], rsp_q[$], ready_q[$];
  logic [DATA_W-1:0] rdata_q[$];
  logic        mosi_q[$];
  int          rise_cnt = 0, sclk_bad = 0, irq_rise_cnt = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_cs && !cs_n) cs_fall_q.push_back(cyc);
      if (!prev_cs && cs_n) cs_rise_q.push_back(cyc);
      if (!prev_sclk && sclk) begin
        mosi_q.push_back(mosi);
        rise_cnt++;
      end
      if (rsp_valid) begin
        rsp_q.push_back(cyc);
        rdata_q.push_back(rsp_rdata);
      end
      if (!prev_ready && req_ready) ready_q.push_back(cyc);
      if (sclk && cs_n) sclk_bad++;
      if (irq_rise) irq_rise_cnt++;
    end
    prev_cs    = rst_n ? cs_n : 1'b1;
    prev_sclk  = rst_n ? sclk : 1'b0;
    prev_ready = rst_n ? req_ready : 1'b1;
  end

  // SPI slave: presents slave_tx MSB first, first bit on cs_n fall, then one bit per sclk fall.
  logic [N-1:0] slave_tx = '0;
  int sbit = 0;
  always @(negedge cs_n) begin
    sbit = 0;
    miso = slave_tx[N-1];
  end
  always @(negedge sclk) begin
    if (!cs_n) begin
      sbit++;
      miso = (sbit < N) ? slave_tx[N-1-sbit] : 1'b0;
    end
  end

  task automatic clear_records();
    cs_fall_q.delete(); cs_rise_q.delete(); rsp_q.delete(); ready_q.delete();
    rdata_q.delete(); mosi_q.delete();
    rise_cnt = 0; sclk_bad = 0; irq_rise_cnt = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one request on a cycle where req_ready is high; c0 is the accept cycle.
  task automatic start_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [DATA_W-1:0] wdata, output int c0);
    int i;
    i = 0;
    @(negedge clk);
    while (!req_ready && i < FRAME_CYC) begin
      @(negedge clk);
      i++;
    end
    req_cmd = cmd; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_ready_events(input int count, input string name);
    int i;
    i = 0;
    while (ready_q.size() < count && i < FRAME_CYC * count) begin
      step();
      i++;
    end
    checks++;
    if (ready_q.size() < count) begin
      errors++;
      $display("[TB] FAIL %s timeout: req_ready returns seen %0d, required %0d", name, ready_q.size(), count);
    end
  endtask

  task automatic check_one_frame(input string name, input int c0,
                                 input logic [N-1:0] exp_mosi, input logic [DATA_W-1:0] exp_rdata);
    logic [N-1:0] got;
    got = '0;
    foreach (mosi_q[i]) got = {got[N-2:0], mosi_q[i]};
    checks++;
    if (mosi_q.size() != N || got !== exp_mosi) begin
      errors++;
      $display("[TB] FAIL %s mosi: got %h (%0d rises) expected %h (%0d rises)", name, got, mosi_q.size(), exp_mosi, N);
    end
    checks++;
    if (cs_fall_q.size() != 1 || cs_fall_q[0] != c0 + 1) begin
      errors++;
      $display("[TB] FAIL %s cs_fall: got %0d events first=%0d expected cycle %0d", name, cs_fall_q.size(), cs_fall_q.size() ? cs_fall_q[0] - c0 : -1, 1);
    end
    checks++;
    if (cs_rise_q.size() != 1 || cs_rise_q[0] != c0 + 1 + (2 * N + 1) * D) begin
      errors++;
      $display("[TB] FAIL %s cs_rise: got rel %0d expected %0d", name, cs_rise_q.size() ? cs_rise_q[0] - c0 : -1, 1 + (2 * N + 1) * D);
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] != c0 + 1 + (2 * N + 1) * D || rdata_q[0] !== exp_rdata) begin
      errors++;
      $display("[TB] FAIL %s rsp: got %0d pulses rel %0d data %h expected 1 pulse rel %0d data %h", name, rsp_q.size(), rsp_q.size() ? rsp_q[0] - c0 : -1, rdata_q.size() ? rdata_q[0] : '0, 1 + (2 * N + 1) * D, exp_rdata);
    end
    checks++;
    if (ready_q.size() < 1 || ready_q[0] != c0 + 1 + (2 * N + 2) * D) begin
      errors++;
      $display("[TB] FAIL %s ready: got rel %0d expected %0d", name, ready_q.size() ? ready_q[0] - c0 : -1, 1 + (2 * N + 2) * D);
    end
    checks++;
    if (sclk_bad != 0) begin
      errors++;
      $display("[TB] FAIL %s sclk_while_idle: got %0d cycles expected 0", name, sclk_bad);
    end
  endtask

  task automatic test_reset();
    int bad;
    checks++;
    if ({cs_n, sclk, mosi, req_ready, busy, rsp_valid, irq_sync, irq_rise} !== 8'b1001_0000 || rsp_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got cs_n=%b sclk=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h is=%b ir=%b", cs_n, sclk, mosi, req_ready, busy, rsp_valid, rsp_rdata, irq_sync, irq_rise);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_records();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!req_ready || !cs_n || sclk || busy) bad++;
    end
    checks++;
    if (bad != 0 || irq_rise_cnt != 0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got %0d bad cycles %0d irq pulses expected 0 and 0", bad, irq_rise_cnt);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [N-1:0] tx);
    int c0;
    clear_records();
    slave_tx = tx;
    start_frame(cmd, addr, wdata, c0);
    wait_ready_events(1, name);
    check_one_frame(name, c0, {cmd, addr, wdata}, tx[DATA_W-1:0]);
  endtask

  task automatic test_write();
    run_frame("write", 8'h01, 8'h10, 16'hBEEF, N'($urandom));
  endtask

  task automatic test_read();
    run_frame("read", 8'h81, 8'h20, 16'h0000, {16'($urandom), 16'h1234});
    checks++;
    if (rdata_q.size() != 1 || rsp_rdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL read_data: got %h expected 1234", rsp_rdata);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++)
      run_frame($sformatf("rand%0d", f), 8'($urandom), 8'($urandom), 16'($urandom), N'($urandom));
  endtask

  task automatic test_back_to_back();
    int c0, i;
    logic [N-1:0] got;
    logic [N-1:0] exp_b;
    clear_records();
    slave_tx = N'($urandom);
    start_frame(8'h02, 8'h33, 16'hA5C3, c0);
    req_valid = 1'b1;
    req_cmd = 8'h84; req_addr = 8'h7E; req_wdata = 16'h0F0F;
    exp_b = {8'h84, 8'h7E, 16'h0F0F};
    i = 0;
    while (cs_fall_q.size() < 2 && i < 2 * FRAME_CYC) begin
      step();
      i++;
    end
    req_valid = 1'b0;
    wait_ready_events(2, "b2b");
    repeat (3 * FRAME_CYC) step();
    checks++;
    if (cs_fall_q.size() != 2 || cs_rise_q.size() < 1 || cs_fall_q[1] - cs_rise_q[0] != D + 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got %0d frames gap %0d expected 2 frames gap %0d", cs_fall_q.size(), (cs_fall_q.size() > 1 && cs_rise_q.size() > 0) ? cs_fall_q[1] - cs_rise_q[0] : -1, D + 1);
    end
    got = '0;
    for (int k = N; k < mosi_q.size() && k < 2 * N; k++) got = {got[N-2:0], mosi_q[k]};
    checks++;
    if (mosi_q.size() != 2 * N || got !== exp_b || rsp_q.size() != 2 || rdata_q[1] !== slave_tx[DATA_W-1:0]) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %0d rises mosi %h %0d rsp expected %0d rises mosi %h 2 rsp", mosi_q.size(), got, rsp_q.size(), 2 * N, exp_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0, i;
    clear_records();
    start_frame(8'h03, 8'h44, 16'h1357, c0);
    i = 0;
    while (rise_cnt < 10 && i < FRAME_CYC) begin
      @(posedge clk);
      #1;
      i++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || mosi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got cs_n=%b sclk=%b busy=%b rdy=%b mosi=%b expected 1 0 0 1 0", cs_n, sclk, busy, req_ready, mosi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CYC) step();
    checks++;
    if (rsp_q.size() != 0 || cs_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_no_rsp: got %0d rsp cs_n=%b expected 0 rsp cs_n=1", rsp_q.size(), cs_n);
    end
    run_frame("after_reset", 8'h05, 8'h66, 16'hC0DE, N'($urandom));
  endtask

  task automatic test_irq();
    int c0;
    logic s1, s2, r2, r3;
    clear_records();
    start_frame(8'h06, 8'h77, 16'h2468, c0);
    repeat ($urandom_range(10, 100)) @(posedge clk);
    #($urandom_range(1, 8));
    irq_in = 1'b1;
    @(posedge clk); #1 s1 = irq_sync;
    @(posedge clk); #1 s2 = irq_sync; r2 = irq_rise;
    @(posedge clk); #1 r3 = irq_rise;
    checks++;
    if (s1 !== 1'b0 || s2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_sync_delay: got %b%b after edges 1,2 expected 01", s1, s2);
    end
    checks++;
    if (r2 !== 1'b1 || r3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_rise_width: got %b%b expected 10", r2, r3);
    end
    repeat (40) step();
    checks++;
    if (irq_rise_cnt != 1 || irq_sync !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_single_pulse: got %0d pulses expected 1", irq_rise_cnt);
    end
    irq_in = 1'b0;
    wait_ready_events(1, "irq_frame");
  endtask

  initial begin
    #23;
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
